dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache for the MIPS memory stage. It answers MEM-stage load/store requests and drives `dhit`, the stall qualifier that gates the MEM/WB pipeline register and the upstream stages. Read misses refill a whole line over a simple req/ready memory port; stores are written through to memory before `dhit` is returned.

## Interface
Parameters:
- SETS, 16: number of lines, power of two ≥2. INDEX_W = log2(SETS).
- LINE_WORDS, 4: 32-bit words per line, power of two ≥2. OFF_W = log2(LINE_WORDS).
- TAG_W is derived: 32 − 2 − OFF_W − INDEX_W (24 at defaults).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- mem_read  in  1  MEM-stage load request
- mem_write  in  1  MEM-stage store request; wins if both are high
- addr  in  32  byte address; addr[1:0] ignored
- wdata  in  32  store data
- rdata  out  32  load data, combinational from the data array
- dhit  out  1  1 = request satisfied this cycle, pipeline may advance
- m_req  out  1  memory request, held until accepted
- m_we  out  1  1 = write, 0 = read; valid while m_req=1
- m_addr  out  32  word-aligned memory address
- m_wdata  out  32  write data
- m_rdata  in  32  read data, valid when m_ready=1
- m_ready  in  1  one-cycle accept/complete pulse. May be high in the same cycle m_req rises.

## Operation
- Address split: tag = addr[31 -: TAG_W], index = next INDEX_W bits, word = addr[OFF_W+1:2].
- Storage: valid[SETS] in flops, cleared by reset. tag[SETS] and data[SETS][LINE_WORDS] have no reset.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - No request: dhit=1.
  - Read hit (valid & tag match): dhit=1 and rdata=data[index][word].
  - Read miss: dhit=0. Next state REFILL. Clear valid[index] and reset the word counter to 0.
  - Write (hit or miss): dhit=0. Next state WRITE.
- REFILL:
  - Drive m_req=1, m_we=0, m_addr={tag,index,cnt,2'b00}.
  - On each m_ready, write m_rdata to data[index][cnt] and increment cnt.
  - On m_ready with cnt=LINE_WORDS−1, also write tag[index], set valid[index], and return to IDLE.
  - The request is then a hit in IDLE. dhit=0 throughout REFILL.
- WRITE:
  - Drive m_req=1, m_we=1, m_addr={addr[31:2],2'b00}, m_wdata=wdata.
  - On m_ready: if the line is valid and the tag matches, update data[index][word]; a miss allocates nothing. Next state DONE.
  - dhit=0.
- DONE: dhit=1 for exactly one cycle, which retires the store without reissuing it. Next state IDLE.
- While m_req=1, m_addr, m_we and m_wdata are stable until m_ready. m_req=0 in IDLE and DONE.
- The CPU holds mem_read, mem_write, addr and wdata stable while dhit=0. The block does not re-sample them in REFILL or WRITE.
- The word counter is OFF_W bits wide and wraps only at refill completion.

## Timing
- Reset values: state=IDLE, all valid=0, cnt=0, m_req=0, m_we=0, m_addr=0, m_wdata=0. dhit=1 if idle; rdata is don't-care.
- Read hit: 0 added cycles; dhit=1 in the request cycle.
- Read miss with m_ready tied high:
  - dhit=0 in cycles 0 through LINE_WORDS.
  - dhit=1 in cycle LINE_WORDS+1 (cycle 5 at defaults).
  - Each wait cycle of memory adds one cycle.
- Store with m_ready tied high: dhit=0 in cycles 0–1, dhit=1 in cycle 2 (DONE).
- Reset mid-REFILL or mid-WRITE:
  - Abort immediately; the line stays invalid.
  - The memory side must tolerate an abandoned request.
- A store to the line being refilled cannot occur, because the pipeline is stalled.

## Test plan
- Reset, then idle: dhit=1, m_req=0. A read of 0x00000040 misses; all valid bits read 0.
- Cold read miss at 0x00001234, m_ready high with 2-cycle waits per word:
  - m_addr goes 0x1230, 0x1234, 0x1238, 0x123C.
  - Afterwards dhit=1 and rdata = memory word at 0x1234.
- Read hit after refill at 0x00001238: dhit=1 in the same cycle, m_req stays 0, rdata correct.
- Write hit 0xDEADBEEF to 0x00001234:
  - One memory write is issued and dhit pulses for one cycle.
  - A subsequent read of 0x1234 hits with 0xDEADBEEF.
- Write miss to 0x00005000: memory write occurs, no allocation, and a later read of 0x5000 misses.
- Conflict and reset:
  - Read 0x00000000 then 0x00000400 (same index): the second evicts the first, so re-reading 0x0 misses.
  - Assert reset during the third refill word: state=IDLE, m_req=0, and the next read of that line misses.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response and memory-side req/ready signals of the data cache.
// The slave modport is the cache's view; master is the CPU/memory environment.
interface dcache_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dhit;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  mem_read, mem_write, addr, wdata, m_rdata, m_ready,
    output rdata, dhit, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output mem_read, mem_write, addr, wdata, m_rdata, m_ready,
    input  rdata, dhit, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate D-cache: read hit 0 cycles, miss refills a line.
// dhit=0 stalls the pipeline; memory requests hold address/data until m_ready.
module dcache_ctrl #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  dcache_ctrl_if.slave io_bus
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int TAG_W   = 32 - 2 - OFF_W - INDEX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS][LINE_WORDS];
  logic [OFF_W-1:0] r_cnt;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [OFF_W-1:0]   w_word;
  logic               w_hit;
  logic               w_last;
  logic               w_refill_ack;
  logic               w_write_ack;
  logic               w_unused_ok;

  assign w_tag        = io_bus.addr[31 -: TAG_W];
  assign w_index      = io_bus.addr[2+OFF_W +: INDEX_W];
  assign w_word       = io_bus.addr[2 +: OFF_W];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last       = (r_cnt == OFF_W'(LINE_WORDS - 1));
  assign w_refill_ack = (r_state == S_REFILL) && io_bus.m_ready;
  assign w_write_ack  = (r_state == S_WRITE) && io_bus.m_ready;
  assign w_unused_ok  = &{1'b0, io_bus.addr[1:0]};

  // Valid is dropped at miss detection so an aborted refill leaves the line invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.mem_write) begin
            r_state <= S_WRITE;
          end else if (io_bus.mem_read && !w_hit) begin
            r_valid[w_index] <= 1'b0;
            r_cnt            <= '0;
            r_state          <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (io_bus.m_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[w_index] <= 1'b1;
              r_state          <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (io_bus.m_ready) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill_ack) begin
      r_data[w_index][r_cnt] <= io_bus.m_rdata;
      if (w_last) r_tag[w_index] <= w_tag;
    end else if (w_write_ack && w_hit) begin
      r_data[w_index][w_word] <= io_bus.wdata;
    end
  end

  logic        w_dhit;
  logic        w_m_req;
  logic        w_m_we;
  logic [31:0] w_m_addr;
  logic [31:0] w_m_wdata;

  always_comb begin
    w_dhit    = 1'b0;
    w_m_req   = 1'b0;
    w_m_we    = 1'b0;
    w_m_addr  = '0;
    w_m_wdata = '0;
    case (r_state)
      S_IDLE:   w_dhit = !io_bus.mem_write && !(io_bus.mem_read && !w_hit);
      S_REFILL: begin
        w_m_req  = 1'b1;
        w_m_addr = {w_tag, w_index, r_cnt, 2'b00};
      end
      S_WRITE: begin
        w_m_req   = 1'b1;
        w_m_we    = 1'b1;
        w_m_addr  = {io_bus.addr[31:2], 2'b00};
        w_m_wdata = io_bus.wdata;
      end
      default:  w_dhit = 1'b1;
    endcase
  end

  assign io_bus.dhit    = w_dhit;
  assign io_bus.m_req   = w_m_req;
  assign io_bus.m_we    = w_m_we;
  assign io_bus.m_addr  = w_m_addr;
  assign io_bus.m_wdata = w_m_wdata;
  assign io_bus.rdata   = r_data[w_index][w_word];
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural cache/memory model, random-wait memory responder.
module tb_dcache_ctrl;
  localparam int SETS = 16;
  localparam int LW   = 4;

  logic clk;
  logic reset;
  dcache_ctrl_if bus ();

  dcache_ctrl #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: written words override a fixed pattern.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q [$];
  int          n_wr = 0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          mem_wait = 0;

  // Cache model: which line currently holds which tag.
  bit          mvalid [SETS];
  int unsigned mtag   [SETS];

  function automatic logic [31:0] memval(logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    int unsigned idx = (a / (4 * LW)) % SETS;
    int unsigned tg  = a / (4 * LW * SETS);
    return mvalid[idx] && (mtag[idx] == tg);
  endfunction

  function automatic void model_read(logic [31:0] a);
    int unsigned idx = (a / (4 * LW)) % SETS;
    mvalid[idx] = 1'b1;
    mtag[idx]   = a / (4 * LW * SETS);
  endfunction

  // Memory responder: accepts after mem_wait idle cycles, garbage data otherwise.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_rdata = $urandom;
      if (reset || !bus.m_req) begin
        bus.m_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt >= mem_wait) begin
        bus.m_ready = 1'b1;
        wcnt = 0;
        if (bus.m_we) begin
          mem[bus.m_addr] = bus.m_wdata;
          last_wr_addr = bus.m_addr;
          last_wr_data = bus.m_wdata;
          n_wr++;
        end else begin
          rd_q.push_back(bus.m_addr);
          bus.m_rdata = memval(bus.m_addr);
        end
      end else begin
        bus.m_ready = 1'b0;
        wcnt++;
      end
    end
  end

  // Drives one request from just after a negedge; returns stall cycles and rdata at dhit.
  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = is_wr;
    bus.mem_read  = !is_wr;
    #1;
    stalls = 0;
    while (bus.dhit !== 1'b1 && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    rd = bus.rdata;
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    int s;
    logic [31:0] rd;
    #1;
    n_checks++; if (bus.dhit !== 1'b1) $display("FAIL reset_dhit: got %b want 1", bus.dhit); else n_pass++;
    n_checks++; if (bus.m_req !== 1'b0) $display("FAIL reset_m_req: got %b want 0", bus.m_req); else n_pass++;
    n_checks++; if (bus.m_we !== 1'b0) $display("FAIL reset_m_we: got %b want 0", bus.m_we); else n_pass++;
    n_checks++; if (bus.m_addr !== 32'h0) $display("FAIL reset_m_addr: got %h want 0", bus.m_addr); else n_pass++;
    n_checks++; if (bus.m_wdata !== 32'h0) $display("FAIL reset_m_wdata: got %h want 0", bus.m_wdata); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    mem_wait = 0;
    access(1'b0, 32'h0000_0040, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL reset_cold_miss_stalls: got %0d want %0d", s, LW + 1); else n_pass++;
    n_checks++; if (rd !== memval(32'h40)) $display("FAIL reset_cold_miss_rdata: got %h want %h", rd, memval(32'h40)); else n_pass++;
    model_read(32'h40);
  endtask

  task automatic test_cold_miss();
    int s;
    int base;
    logic [31:0] rd;
    logic [31:0] exp_a;
    mem_wait = 2;
    base = rd_q.size();
    access(1'b0, 32'h0000_1234, 32'h0, s, rd);
    n_checks++; if (s !== 1 + LW * 3) $display("FAIL miss_wait_stalls: got %0d want %0d", s, 1 + LW * 3); else n_pass++;
    n_checks++; if (rd_q.size() !== base + LW) $display("FAIL miss_req_count: got %0d want %0d", rd_q.size() - base, LW); else n_pass++;
    for (int i = 0; i < LW && base + i < rd_q.size(); i++) begin
      exp_a = 32'h1230 + 32'(4 * i);
      n_checks++; if (rd_q[base + i] !== exp_a) $display("FAIL miss_m_addr%0d: got %h want %h", i, rd_q[base + i], exp_a); else n_pass++;
    end
    n_checks++; if (rd !== memval(32'h1234)) $display("FAIL miss_rdata: got %h want %h", rd, memval(32'h1234)); else n_pass++;
    model_read(32'h1234);
  endtask

  task automatic test_read_hit();
    int s;
    int base;
    logic [31:0] rd;
    base = rd_q.size();
    access(1'b0, 32'h0000_1238, 32'h0, s, rd);
    n_checks++; if (s !== 0) $display("FAIL hit_stalls: got %0d want 0", s); else n_pass++;
    n_checks++; if (rd_q.size() !== base) $display("FAIL hit_no_mem_req: got %0d reqs want 0", rd_q.size() - base); else n_pass++;
    n_checks++; if (rd !== memval(32'h1238)) $display("FAIL hit_rdata: got %h want %h", rd, memval(32'h1238)); else n_pass++;
  endtask

  task automatic test_write_hit();
    int s;
    int w0;
    logic [31:0] rd;
    mem_wait = 0;
    w0 = n_wr;
    access(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, s, rd);
    n_checks++; if (s !== 2) $display("FAIL wr_hit_stalls: got %0d want 2", s); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (n_wr !== w0 + 1) $display("FAIL wr_hit_write_count: got %0d want 1", n_wr - w0); else n_pass++;
    n_checks++; if (last_wr_addr !== 32'h1234 || last_wr_data !== 32'hDEAD_BEEF)
      $display("FAIL wr_hit_mem: got %h/%h want 00001234/deadbeef", last_wr_addr, last_wr_data); else n_pass++;
    access(1'b0, 32'h0000_1234, 32'h0, s, rd);
    n_checks++; if (s !== 0) $display("FAIL wr_hit_reread_stalls: got %0d want 0", s); else n_pass++;
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL wr_hit_reread_rdata: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_write_miss();
    int s;
    logic [31:0] rd;
    logic [31:0] d;
    d = $urandom;
    mem_wait = 1;
    access(1'b1, 32'h0000_5000, d, s, rd);
    n_checks++; if (s !== 3) $display("FAIL wr_miss_stalls: got %0d want 3", s); else n_pass++;
    n_checks++; if (memval(32'h5000) !== d) $display("FAIL wr_miss_mem: got %h want %h", memval(32'h5000), d); else n_pass++;
    mem_wait = 0;
    access(1'b0, 32'h0000_5000, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL wr_miss_no_alloc: got %0d stalls want %0d", s, LW + 1); else n_pass++;
    n_checks++; if (rd !== d) $display("FAIL wr_miss_readback: got %h want %h", rd, d); else n_pass++;
    model_read(32'h5000);
  endtask

  task automatic test_conflict();
    int s;
    logic [31:0] rd;
    mem_wait = 0;
    access(1'b0, 32'h0000_0000, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL conflict_first: got %0d stalls want %0d", s, LW + 1); else n_pass++;
    access(1'b0, 32'h0000_0400, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL conflict_evict: got %0d stalls want %0d", s, LW + 1); else n_pass++;
    n_checks++; if (rd !== memval(32'h400)) $display("FAIL conflict_rdata: got %h want %h", rd, memval(32'h400)); else n_pass++;
    access(1'b0, 32'h0000_0000, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL conflict_remiss: got %0d stalls want %0d", s, LW + 1); else n_pass++;
    model_read(32'h0);
  endtask

  task automatic test_reset_midrefill();
    int s;
    int base;
    logic [31:0] rd;
    mem_wait = 2;
    base = rd_q.size();
    bus.addr     = 32'h0000_2000;
    bus.mem_read = 1'b1;
    for (int k = 0; k < 100 && rd_q.size() < base + 2; k++) begin
      @(negedge clk);
      #1;
    end
    n_checks++; if (rd_q.size() !== base + 2) $display("FAIL rst_mid_progress: got %0d words want 2", rd_q.size() - base); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.m_req !== 1'b0) $display("FAIL rst_mid_m_req: got %b want 0", bus.m_req); else n_pass++;
    bus.mem_read = 1'b0;
    #1;
    n_checks++; if (bus.dhit !== 1'b1) $display("FAIL rst_mid_idle: got dhit=%b want 1", bus.dhit); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    mem_wait = 0;
    access(1'b0, 32'h0000_2000, 32'h0, s, rd);
    n_checks++; if (s !== LW + 1) $display("FAIL rst_mid_remiss: got %0d stalls want %0d", s, LW + 1); else n_pass++;
    n_checks++; if (rd !== memval(32'h2000)) $display("FAIL rst_mid_rdata: got %h want %h", rd, memval(32'h2000)); else n_pass++;
    model_read(32'h2000);
  endtask

  task automatic test_random();
    int s;
    int exp_s;
    int w0;
    bit is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    for (int n = 0; n < 60; n++) begin
      a        = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      is_wr    = ($urandom_range(0, 9) < 3);
      d        = $urandom;
      mem_wait = $urandom_range(0, 2);
      w0       = n_wr;
      if (is_wr) exp_s = 2 + mem_wait;
      else if (model_hit(a)) exp_s = 0;
      else exp_s = 1 + LW * (mem_wait + 1);
      access(is_wr, a, d, s, rd);
      n_checks++; if (s !== exp_s) $display("FAIL rand%0d_stalls addr=%h wr=%b: got %0d want %0d", n, a, is_wr, s, exp_s); else n_pass++;
      if (is_wr) begin
        n_checks++; if (n_wr !== w0 + 1 || memval(a) !== d)
          $display("FAIL rand%0d_write addr=%h: got %0d writes data %h want 1 %h", n, a, n_wr - w0, memval(a), d); else n_pass++;
      end else begin
        n_checks++; if (rd !== memval(a)) $display("FAIL rand%0d_rdata addr=%h: got %h want %h", n, a, rd, memval(a)); else n_pass++;
        model_read(a);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_midrefill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
